// File: rtl/bus_arbiter21.sv
// bus_arbiter21: two-master round-robin bus arbiter driving the select line
// of a 2:1 bus data mux. Grants, select and timeout are all registered.
// Build option: define ARB_TIMEOUT_EN to compile in the hold-time limit that
// preempts an owner after MAX_HOLD cycles while the other master waits.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no owner, arbitrate any incoming request
// OWN_A | master A owns the bus (gnt_a = 1, sel = 0)
// OWN_B | master B owns the bus (gnt_b = 1, sel = 1)
// TURN  | one dead cycle after an ownership period, arbitrates like IDLE

module bus_arbiter21 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = $clog2(MAX_HOLD)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b,
  output logic sel,
  output logic bus_busy,
  output logic timeout
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B, TURN} state_t;

  state_t state;
  logic   last;  // most recent owner: 0 = A, 1 = B

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] hold_cnt;
  logic             hold_hit;

  // Owner has used its full hold budget
  assign hold_hit = (hold_cnt == HOLD_MAX);
`else
  // Sizing parameters have no effect without the hold-time limit
  logic unused_cfg;
  assign unused_cfg = (MAX_HOLD > CNT_W);
`endif

  // Busy whenever either registered grant is asserted
  assign bus_busy = gnt_a | gnt_b;

  // Arbitration FSM with registered grants, select, last-owner and timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt_a   <= 1'b0;
      gnt_b   <= 1'b0;
      sel     <= 1'b0;
      last    <= 1'b1;  // A wins the first simultaneous request
      timeout <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt <= '0;
`endif
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE, TURN: begin
          // A wins when alone, or when both request and B owned last
          if (req_a && (!req_b || last)) begin
            state <= OWN_A;
            gnt_a <= 1'b1;
            sel   <= 1'b0;
            last  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end else if (req_b) begin
            state <= OWN_B;
            gnt_b <= 1'b1;
            sel   <= 1'b1;
            last  <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        OWN_A: begin
          if (!req_a) begin
            state <= TURN;
            gnt_a <= 1'b0;
          end
`ifdef ARB_TIMEOUT_EN
          else if (req_b && hold_hit) begin
            state   <= TURN;
            gnt_a   <= 1'b0;
            timeout <= 1'b1;
          end else if (!hold_hit) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
`endif
        end
        OWN_B: begin
          if (!req_b) begin
            state <= TURN;
            gnt_b <= 1'b0;
          end
`ifdef ARB_TIMEOUT_EN
          else if (req_a && hold_hit) begin
            state   <= TURN;
            gnt_b   <= 1'b0;
            timeout <= 1'b1;
          end else if (!hold_hit) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
`endif
        end
        default: begin
          state <= IDLE;
          gnt_a <= 1'b0;
          gnt_b <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter21.sv
// Self-checking bench for bus_arbiter21. Each scenario drives requests cycle
// by cycle from a table, pushes the expected output vector
// {gnt_a, gnt_b, sel, bus_busy, timeout} into a scoreboard queue, and pops
// and compares it one edge later.

module tb_bus_arbiter21;

  localparam int MAX_HOLD = 4;

  localparam logic [4:0] E_IDLE0 = 5'b00000;  // no owner, sel = A
  localparam logic [4:0] E_IDLE1 = 5'b00100;  // no owner, sel = B
  localparam logic [4:0] E_A     = 5'b10010;  // A owns
  localparam logic [4:0] E_B     = 5'b01110;  // B owns
  localparam logic [4:0] E_TO0   = 5'b00001;  // A preempted
  localparam logic [4:0] E_TO1   = 5'b00101;  // B preempted

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic req_a = 1'b0;
  logic req_b = 1'b0;
  logic gnt_a, gnt_b, sel, bus_busy, timeout;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [4:0] exp;
    string      tag;
  } exp_t;

  exp_t sb[$];

  bus_arbiter21 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_a    (req_a),
    .req_b    (req_b),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .sel      (sel),
    .bus_busy (bus_busy),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] obs();
    return {gnt_a, gnt_b, sel, bus_busy, timeout};
  endfunction

  always @(negedge clk) begin
    if (gnt_a && gnt_b) begin
      n_fail++;
      $display("FAIL mutex: gnt_a=%b gnt_b=%b, required not both high", gnt_a, gnt_b);
    end
  end

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    sb.push_back('{exp: E_IDLE0, tag: "reset_asserted"});
    #1;
    e = sb.pop_front();
    n_tests++;
    if (obs() !== e.exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", e.tag, obs(), e.exp);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sb.push_back('{exp: E_IDLE0, tag: $sformatf("reset_idle[%0d]", i)});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if (obs() !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %b required %b", e.tag, obs(), e.exp);
      end
    end
  endtask

  task automatic test_single_master();
    logic [6:0] tbl[$];
    exp_t e;
    tbl = '{ {2'b00, E_IDLE0}, {2'b01, E_B}, {2'b01, E_B}, {2'b01, E_B},
             {2'b00, E_IDLE1}, {2'b00, E_IDLE1} };
    for (int i = 0; i < tbl.size(); i++) begin
      req_a = tbl[i][6];
      req_b = tbl[i][5];
      sb.push_back('{exp: tbl[i][4:0], tag: $sformatf("single_b[%0d]", i)});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if (obs() !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %b required %b", e.tag, obs(), e.exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [6:0] tbl[$];
    exp_t e;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tbl = '{ {2'b11, E_A}, {2'b11, E_A}, {2'b11, E_A}, {2'b01, E_IDLE0},
             {2'b01, E_B}, {2'b00, E_IDLE1}, {2'b00, E_IDLE1} };
    for (int i = 0; i < tbl.size(); i++) begin
      req_a = tbl[i][6];
      req_b = tbl[i][5];
      sb.push_back('{exp: tbl[i][4:0], tag: $sformatf("simultaneous[%0d]", i)});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if (obs() !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %b required %b", e.tag, obs(), e.exp);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [6:0] tbl[$];
    exp_t e;
    // Owner holds for two cycles, drops its request for one edge, then
    // re-requests straight away; the other master requests throughout.
    for (int g = 0; g < 6; g++) begin
      if (g % 2 == 0) begin
        tbl.push_back({2'b11, E_A});
        tbl.push_back({2'b11, E_A});
        tbl.push_back({2'b01, E_IDLE0});
      end else begin
        tbl.push_back({2'b11, E_B});
        tbl.push_back({2'b11, E_B});
        tbl.push_back({2'b10, E_IDLE1});
      end
    end
    tbl.push_back({2'b00, E_IDLE1});
    for (int i = 0; i < tbl.size(); i++) begin
      req_a = tbl[i][6];
      req_b = tbl[i][5];
      sb.push_back('{exp: tbl[i][4:0], tag: $sformatf("round_robin[%0d]", i)});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if (obs() !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %b required %b", e.tag, obs(), e.exp);
      end
    end
  endtask

  task automatic test_timeout();
    logic [6:0] tbl[$];
    exp_t e;
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < MAX_HOLD; k++) tbl.push_back({2'b11, E_A});
    tbl.push_back({2'b11, E_TO0});
    for (int k = 0; k < MAX_HOLD; k++) tbl.push_back({2'b11, E_B});
    tbl.push_back({2'b11, E_TO1});
    tbl.push_back({2'b00, E_IDLE1});
`else
    for (int k = 0; k < 25; k++) tbl.push_back({2'b11, E_A});
    tbl.push_back({2'b00, E_IDLE0});
    tbl.push_back({2'b00, E_IDLE0});
`endif
    for (int i = 0; i < tbl.size(); i++) begin
      req_a = tbl[i][6];
      req_b = tbl[i][5];
      sb.push_back('{exp: tbl[i][4:0], tag: $sformatf("timeout[%0d]", i)});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if (obs() !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %b required %b", e.tag, obs(), e.exp);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    logic [6:0] tbl[$];
    exp_t e;
    req_a = 1'b0;
    req_b = 1'b1;
    sb.push_back('{exp: E_B, tag: "midrst_grant_b"});
    @(posedge clk); #1;
    e = sb.pop_front();
    n_tests++;
    if (obs() !== e.exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", e.tag, obs(), e.exp);
    end
    // Reset lands between edges; grant must drop without a clock
    #2;
    rst_n = 1'b0;
    req_a = 1'b1;
    sb.push_back('{exp: E_IDLE0, tag: "midrst_async_drop"});
    #1;
    e = sb.pop_front();
    n_tests++;
    if (obs() !== e.exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", e.tag, obs(), e.exp);
    end
    sb.push_back('{exp: E_IDLE0, tag: "midrst_held"});
    @(posedge clk); #1;
    e = sb.pop_front();
    n_tests++;
    if (obs() !== e.exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", e.tag, obs(), e.exp);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tbl = '{ {2'b11, E_A}, {2'b00, E_IDLE0}, {2'b00, E_IDLE0} };
    for (int i = 0; i < tbl.size(); i++) begin
      req_a = tbl[i][6];
      req_b = tbl[i][5];
      sb.push_back('{exp: tbl[i][4:0], tag: $sformatf("midrst_after[%0d]", i)});
      @(posedge clk); #1;
      e = sb.pop_front();
      n_tests++;
      if (obs() !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %b required %b", e.tag, obs(), e.exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_master();
    test_simultaneous();
    test_round_robin();
    test_timeout();
    test_reset_mid_grant();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
